dffn_bank_arbiter: RTL and testbench

DFFN_BANK_ARBITER -- requirements
Module: dffn_bank_arbiter

---
 rtl/dffn_bank_pkg.sv | 23 ++
 rtl/dffn_bank_arbiter_rr_pick.sv | 31 +++
 rtl/dffn_bank_arbiter.sv | 139 +++++++++++++
 tb/tb_dffn_bank_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffn_bank_pkg.sv
// Shared definitions for the falling-edge register bank arbiter:
// controller state encoding and the index-width helper.
package dffn_bank_pkg;

    // Controller states: wait for a request, drive the bank for one cycle,
    // then report completion for one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACKS  = 2'd2
    } state_t;

    // Number of bits needed to index n items; never less than one bit.
    function automatic int calc_aw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dffn_bank_arbiter_rr_pick.sv
// Combinational round-robin selector. The search starts one position after
// the previous winner and wraps, so the most recent winner has the lowest
// priority on the next arbitration.
module rr_pick
    import dffn_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = calc_aw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   win,
    output logic            vld
);

    // Scan requesters last+1, last+2, ... (mod NREQ) and keep the first hit.
    always_comb begin
        int idx;
        win = '0;
        vld = 1'b0;
        idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!vld && req[idx]) begin
                vld = 1'b1;
                win = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dffn_bank_arbiter.sv
// Round-robin write arbiter in front of a register bank that captures on the
// falling clock edge. One write is in flight at a time: the winning request is
// presented to the bank for a full rising-edge cycle (so the bank's falling
// edge lands mid-cycle on stable data), then acknowledged for one cycle.
module dffn_bank_arbiter
    import dffn_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WORDS = 8,
    parameter int DW    = 8,
    localparam int AW   = calc_aw(WORDS),
    localparam int IW   = calc_aw(NREQ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*AW-1:0] ADDR,
    input  logic [NREQ*DW-1:0] WDATA,
    output logic [NREQ-1:0]    ACK,
    output logic               ERR,
    output logic [WORDS-1:0]   BANK_WE,
    output logic [DW-1:0]      BANK_D,
    output logic               BUSY
);

    state_t          state;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   win_q;
    logic            oor_q;

    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_oor;

    // One-hot word enable for an address; all-zero when the address is past
    // the end of the bank so an out-of-range write touches nothing.
    function automatic logic [WORDS-1:0] word_enable(input logic [AW-1:0] a);
        logic [WORDS-1:0] d;
        d = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (int'(a) == w) begin
                d[w] = 1'b1;
            end
        end
        return d;
    endfunction

    // One-hot acknowledge for a requester index.
    function automatic logic [NREQ-1:0] ack_vector(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (int'(i) == r) begin
                v[r] = 1'b1;
            end
        end
        return v;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req  (REQ),
        .last (last_winner),
        .win  (pick_idx),
        .vld  (pick_vld)
    );

    // Route the current candidate's address and data out of the packed buses.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (int'(pick_idx) == r) begin
                sel_addr = ADDR[r*AW +: AW];
                sel_data = WDATA[r*DW +: DW];
            end
        end
        sel_oor = (int'(sel_addr) >= WORDS);
    end

    // Arbitration/issue/acknowledge sequencer with all outputs registered.
    // BANK_WE and BANK_D are loaded at the arbitration edge, which is what
    // snapshots the request: later changes on ADDR/WDATA cannot reach the bank.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            last_winner <= IW'(NREQ - 1);
            win_q       <= '0;
            oor_q       <= 1'b0;
            ACK         <= '0;
            ERR         <= 1'b0;
            BANK_WE     <= '0;
            BANK_D      <= '0;
            BUSY        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ACK <= '0;
                    ERR <= 1'b0;
                    if (pick_vld) begin
                        win_q   <= pick_idx;
                        oor_q   <= sel_oor;
                        BANK_WE <= word_enable(sel_addr);
                        BANK_D  <= sel_data;
                        BUSY    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The bank has captured at the falling edge; close the
                    // enable but leave BANK_D holding the written value.
                    BANK_WE     <= '0;
                    ACK         <= ack_vector(win_q);
                    ERR         <= oor_q;
                    last_winner <= win_q;
                    state       <= ACKS;
                end
                ACKS: begin
                    ACK   <= '0;
                    ERR   <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BANK_WE <= '0;
                    ACK     <= '0;
                    ERR     <= 1'b0;
                    BUSY    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffn_bank_arbiter.sv
// Self-checking bench for dffn_bank_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model
// and a behavioural falling-edge bank.
module tb_dffn_bank_arbiter;
    import dffn_bank_pkg::*;

    localparam int NREQ  = 4;
    localparam int WORDS = 6;
    localparam int DW    = 8;
    localparam int AW    = calc_aw(WORDS);

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    REQ;
    logic [NREQ*AW-1:0] ADDR;
    logic [NREQ*DW-1:0] WDATA;
    logic [NREQ-1:0]    ACK;
    logic               ERR;
    logic [WORDS-1:0]   BANK_WE;
    logic [DW-1:0]      BANK_D;
    logic               BUSY;

    dffn_bank_arbiter #(
        .NREQ  (NREQ),
        .WORDS (WORDS),
        .DW    (DW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .ACK     (ACK),
        .ERR     (ERR),
        .BANK_WE (BANK_WE),
        .BANK_D  (BANK_D),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural register bank driven by the DUT, capturing on falling edge.
    logic [DW-1:0] bank [WORDS] = '{default: '0};
    always @(negedge CLK) begin
        for (int w = 0; w < WORDS; w++) begin
            if (BANK_WE[w] === 1'b1) bank[w] <= BANK_D;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (one transaction at a time) ----------
    int               m_last;
    int               m_left;     // cycles remaining in the current transaction
    int               m_win;
    int               m_addr;
    logic [DW-1:0]    m_data;
    logic [NREQ-1:0]  e_ack;
    logic             e_err;
    logic             e_busy;
    logic [WORDS-1:0] e_we;
    logic [DW-1:0]    e_d;
    logic [DW-1:0]    e_mem [WORDS] = '{default: '0};
    int               waits [NREQ];

    int               ack_log [$];
    int               ack_cyc [$];

    task automatic model_reset();
        m_last = NREQ - 1;
        m_left = 0;
        m_win  = 0;
        m_addr = 0;
        m_data = '0;
        e_ack  = '0;
        e_err  = 1'b0;
        e_busy = 1'b0;
        e_we   = '0;
        e_d    = '0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
    endtask

    task automatic model_step();
        if (m_left == 0) begin
            e_ack = '0;
            if (REQ != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (REQ[c]) begin
                        m_win = c;
                        break;
                    end
                end
                m_addr = int'(ADDR[m_win*AW +: AW]);
                m_data = WDATA[m_win*DW +: DW];
                e_we   = (m_addr < WORDS) ? (WORDS'(1) << m_addr) : '0;
                e_d    = m_data;
                e_busy = 1'b1;
                m_left = 2;
                chk("starve", waits[m_win], waits[m_win] <= NREQ - 1 ? waits[m_win] : NREQ - 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (i != m_win && REQ[i]) waits[i]++;
                end
                waits[m_win] = 0;
            end else begin
                e_busy = 1'b0;
                e_we   = '0;
            end
        end else if (m_left == 2) begin
            e_we  = '0;
            e_ack = NREQ'(1) << m_win;
            e_err = (m_addr >= WORDS);
            if (m_addr < WORDS) e_mem[m_addr] = m_data;
            m_last = m_win;
            m_left = 1;
        end else begin
            e_ack  = '0;
            e_busy = 1'b0;
            m_left = 0;
        end
    endtask

    // One rising edge: advance the model, then compare every output.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        cyc++;
        #1;
        chk("busy", BUSY, e_busy);
        chk("bank_we", BANK_WE, e_we);
        chk("bank_d", BANK_D, e_d);
        chk("ack", ACK, e_ack);
        if (e_ack != '0) chk("err", ERR, e_err);
        chk("we_onehot", $countones(BANK_WE) <= 1, 1);
        if (ACK != '0) begin
            ack_log.push_back(int'(ACK));
            ack_cyc.push_back(cyc);
        end
        if (auto_drop) REQ = REQ & ~ACK;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        REQ = '0;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
        ADDR[i*AW +: AW]  = AW'(a);
        WDATA[i*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] snap [WORDS];
        int guard;

        RST   = 1'b1;
        REQ   = '0;
        ADDR  = '0;
        WDATA = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ack", ACK, 0);
        chk("rst_err", ERR, 0);
        chk("rst_we", BANK_WE, 0);
        chk("rst_d", BANK_D, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b0;

        // Single write to word 3.
        set_req(0, 3, 8'hA5);
        REQ = 4'b0001;
        cycle();
        chk("t1_we", BANK_WE, 6'h08);
        chk("t1_d", BANK_D, 8'hA5);
        cycle();
        chk("t1_ack", ACK, 4'b0001);
        chk("t1_err", ERR, 0);
        cycle();
        chk("t1_mem3", bank[3], 8'hA5);

        // Contention from a fresh reset: grants in index order, 3 cycles apart.
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i, DW'(8'h10 + i));
        REQ = 4'b1111;
        ack_log.delete();
        ack_cyc.delete();
        repeat (12) cycle();
        chk("cont_n", ack_log.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk("cont_order", (j < ack_log.size()) ? ack_log[j] : 0, 1 << j);
            if (j > 0) chk("cont_gap", (j < ack_cyc.size()) ? ack_cyc[j] - ack_cyc[j-1] : 0, 3);
        end

        // Fairness wrap: after requester 2, REQ=0101 picks 0.
        set_req(2, 5, 8'h2C);
        REQ = 4'b0100;
        repeat (3) cycle();
        set_req(0, 1, 8'h3D);
        set_req(2, 2, 8'h4E);
        REQ = 4'b0101;
        ack_log.delete();
        repeat (3) cycle();
        chk("wrap_n", ack_log.size(), 1);
        chk("wrap_win", (ack_log.size() > 0) ? ack_log[0] : 0, 4'b0001);
        repeat (3) cycle();

        // Out-of-range address: no enable, ACK with ERR.
        for (int w = 0; w < WORDS; w++) snap[w] = bank[w];
        set_req(0, 7, 8'h5A);
        REQ = 4'b0001;
        cycle();
        chk("oor_we", BANK_WE, 0);
        cycle();
        chk("oor_ack", ACK, 4'b0001);
        chk("oor_err", ERR, 1);
        cycle();
        for (int w = 0; w < WORDS; w++) chk("oor_bank", bank[w], snap[w]);

        // Data hold: WDATA changes after the sample do not reach the bank.
        set_req(0, 1, 8'h11);
        REQ = 4'b0001;
        cycle();
        set_req(0, 1, 8'h22);
        cycle();
        cycle();
        chk("hold_mem1", bank[1], 8'h11);

        // Reset asserted during ISSUE aborts the write asynchronously.
        set_req(1, 4, 8'h99);
        REQ = 4'b0010;
        cycle();
        chk("pre_rst_busy", BUSY, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_we", BANK_WE, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_ack", ACK, 0);
        model_reset();
        REQ = '0;
        @(posedge CLK);
        #1;
        chk("arst_noack", ACK, 0);
        RST = 1'b0;
        set_req(0, 2, 8'h77);
        REQ = 4'b0001;
        cycle();
        chk("post_rst_we", BANK_WE, 6'h04);
        cycle();
        chk("post_rst_ack", ACK, 4'b0001);
        cycle();
        chk("abort_mem4", bank[4], e_mem[4]);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!REQ[i] && $urandom_range(99) < 35) begin
                    set_req(i, $urandom_range(WORDS + 1), DW'($urandom));
                    REQ[i] = 1'b1;
                end else if (REQ[i] && $urandom_range(99) < 10) begin
                    set_req(i, $urandom_range(WORDS + 1), DW'($urandom));
                end
            end
            if (m_left == 2 && $urandom_range(99) < 15) REQ[m_win] = 1'b0;
            cycle();
        end
        guard = 0;
        while ((REQ != '0 || m_left != 0) && guard < 60) begin
            cycle();
            guard++;
        end
        chk("drain", guard < 60, 1);
        for (int w = 0; w < WORDS; w++) chk("rand_bank", bank[w], e_mem[w]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
